// File: rtl/wb_slave_arbiter.sv
// Two-master Wishbone arbiter in front of a single slave port.
// Master 0 is the management SoC bus and master 1 is an auxiliary test master.
// Contention is settled round-robin. Each grant covers exactly one transfer.
// A watchdog ends a transfer with err if the slave never acks.
module wb_slave_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   // master 0
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   // master 1
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   // slave
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   // debug
   output logic [1:0]  gnt_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_t;

   // Counter value seen in the last BUSY cycle before the watchdog fires.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state;
   logic             owner;       // 0 = master 0, 1 = master 1
   logic             last_grant;  // master that finished most recently
   logic [CNT_W-1:0] count;

   logic             m0_req;
   logic             m1_req;
   logic             next_owner;
   logic             busy;
   logic             in_err;

   logic             own_cyc;
   logic             own_stb;
   logic             own_we;
   logic [31:0]      own_adr;
   logic [31:0]      own_dat;
   logic [3:0]       own_sel;

   assign m0_req = m0_cyc_i & m0_stb_i;
   assign m1_req = m1_cyc_i & m1_stb_i;
   assign busy   = (state == ST_BUSY);
   assign in_err = (state == ST_ERR);

   // A lone requester wins. A tie goes to the master that did not finish last.
   assign next_owner = (m0_req && m1_req) ? ~last_grant : m1_req;

   // Select the current owner's request signals.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
      own_cyc = m0_cyc_i;
      own_stb = m0_stb_i;
      own_we  = m0_we_i;
      own_adr = m0_adr_i;
      own_dat = m0_dat_i;
      own_sel = m0_sel_i;
      if (owner) begin
         own_cyc = m1_cyc_i;
         own_stb = m1_stb_i;
         own_we  = m1_we_i;
         own_adr = m1_adr_i;
         own_dat = m1_dat_i;
         own_sel = m1_sel_i;
      end
   end

   // The slave port is driven only while a grant is in BUSY.
   // An owner dropping cyc takes the slave strobe down in the same cycle.
   assign s_cyc_o = busy & own_cyc & own_stb;
   assign s_stb_o = busy & own_cyc & own_stb;
   assign s_we_o  = busy & own_we;
   assign s_adr_o = busy ? own_adr : '0;
   assign s_dat_o = busy ? own_dat : '0;
   assign s_sel_o = busy ? own_sel : '0;

   // Route slave responses back to the owner only. The non-owner always sees zeros.
   assign m0_ack_o = busy & ~owner & s_ack_i;
   assign m1_ack_o = busy &  owner & s_ack_i;
   assign m0_dat_o = (busy & ~owner) ? s_dat_i : '0;
   assign m1_dat_o = (busy &  owner) ? s_dat_i : '0;
   assign m0_err_o = in_err & ~owner;
   assign m1_err_o = in_err &  owner;

   // Arbitration FSM: grant, wait for ack / abort / timeout, then return to IDLE.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         count      <= '0;
         gnt_o      <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (m0_req || m1_req) begin
                  state <= ST_BUSY;
                  owner <= next_owner;
                  count <= '0;
                  gnt_o <= next_owner ? 2'b10 : 2'b01;
               end
            end
            ST_BUSY: begin
               // An ack on the watchdog's last cycle still counts as a normal completion.
               if (s_ack_i || !own_cyc) begin
                  state      <= ST_IDLE;
                  last_grant <= owner;
                  gnt_o      <= 2'b00;
               end else if (count == LAST_CNT) begin
                  state <= ST_ERR;
               end else begin
                  count <= count + 1'b1;
               end
            end
            ST_ERR: begin
               state      <= ST_IDLE;
               last_grant <= owner;
               gnt_o      <= 2'b00;
            end
            default: begin
               state <= ST_IDLE;
               gnt_o <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Directed bench for wb_slave_arbiter with a short watchdog (TIMEOUT_CYC = 8).
// Inputs change 1 time unit after the rising edge. Outputs are checked before
// the next edge, so the combinational paths are settled when they are sampled.
module tb_wb_slave_arbiter;

   logic        wb_clk_i;
   logic        wb_rst_ni;
   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [31:0] m0_adr_i, m0_dat_i;
   logic [3:0]  m0_sel_i;
   logic        m0_ack_o, m0_err_o;
   logic [31:0] m0_dat_o;
   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [31:0] m1_adr_i, m1_dat_i;
   logic [3:0]  m1_sel_i;
   logic        m1_ack_o, m1_err_o;
   logic [31:0] m1_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic        s_ack_i;
   logic [31:0] s_dat_i;
   logic [1:0]  gnt_o;

   int          vectors;
   int          miscompares;
   logic        eo;  // expected owner in the contention loop

   wb_slave_arbiter #(
      .TIMEOUT_CYC (8),
      .CNT_W       (4)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .m0_cyc_i  (m0_cyc_i),
      .m0_stb_i  (m0_stb_i),
      .m0_we_i   (m0_we_i),
      .m0_adr_i  (m0_adr_i),
      .m0_dat_i  (m0_dat_i),
      .m0_sel_i  (m0_sel_i),
      .m0_ack_o  (m0_ack_o),
      .m0_err_o  (m0_err_o),
      .m0_dat_o  (m0_dat_o),
      .m1_cyc_i  (m1_cyc_i),
      .m1_stb_i  (m1_stb_i),
      .m1_we_i   (m1_we_i),
      .m1_adr_i  (m1_adr_i),
      .m1_dat_i  (m1_dat_i),
      .m1_sel_i  (m1_sel_i),
      .m1_ack_o  (m1_ack_o),
      .m1_err_o  (m1_err_o),
      .m1_dat_o  (m1_dat_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_we_o    (s_we_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_sel_o   (s_sel_o),
      .s_ack_i   (s_ack_i),
      .s_dat_i   (s_dat_i),
      .gnt_o     (gnt_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Global time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      eo = 1'b0;
      wb_rst_ni = 1'b0;
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
      s_ack_i = 0; s_dat_i = '0;

      // ---- reset state ----
      tick();
      check("rst_gnt",    32'(gnt_o),    32'h0);
      check("rst_s_cyc",  32'(s_cyc_o),  32'h0);
      check("rst_s_stb",  32'(s_stb_o),  32'h0);
      check("rst_s_adr",  s_adr_o,       32'h0);
      check("rst_m0_ack", 32'(m0_ack_o), 32'h0);
      check("rst_m1_err", 32'(m1_err_o), 32'h0);
      tick();
      wb_rst_ni = 1'b1;
      tick();

      // ---- contention: both masters request at the same edge, 4 reads each ----
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_0100; m0_sel_i = 4'hF;
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h0000_0200; m1_sel_i = 4'hF;
      for (int i = 0; i < 8; i++) begin
         eo = (i % 2) == 1;
         tick();
         check("arb_gnt", 32'(gnt_o), eo ? 32'h2 : 32'h1);
         check("arb_adr", s_adr_o, eo ? 32'h0000_0200 : 32'h0000_0100);
         s_ack_i = 1;
         s_dat_i = eo ? 32'h22 : 32'h11;
         #1;
         check("arb_m0_ack", 32'(m0_ack_o), eo ? 32'h0 : 32'h1);
         check("arb_m1_ack", 32'(m1_ack_o), eo ? 32'h1 : 32'h0);
         check("arb_m0_dat", m0_dat_o, eo ? 32'h0 : 32'h11);
         check("arb_m1_dat", m1_dat_o, eo ? 32'h22 : 32'h0);
         tick();
         s_ack_i = 0;
         s_dat_i = '0;
         if (i == 6) begin
            m0_cyc_i = 0; m0_stb_i = 0;
         end
         #1;
         check("arb_idle_gnt", 32'(gnt_o), 32'h0);
      end
      m1_cyc_i = 0; m1_stb_i = 0;
      tick();

      // ---- m0 single write, slave acks one cycle after stb ----
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
      m0_adr_i = 32'h3000_0000; m0_dat_i = 32'hDEAD_BEEF; m0_sel_i = 4'hF;
      #1;
      check("wr_idle_s_cyc", 32'(s_cyc_o), 32'h0);
      check("wr_idle_s_adr", s_adr_o, 32'h0);
      tick();
      check("wr_s_stb", 32'(s_stb_o), 32'h1);
      check("wr_s_we",  32'(s_we_o),  32'h1);
      check("wr_s_adr", s_adr_o, 32'h3000_0000);
      check("wr_s_dat", s_dat_o, 32'hDEAD_BEEF);
      check("wr_s_sel", 32'(s_sel_o), 32'hF);
      check("wr_gnt",   32'(gnt_o), 32'h1);
      check("wr_m0_ack_early", 32'(m0_ack_o), 32'h0);
      tick();
      s_ack_i = 1;
      #1;
      check("wr_m0_ack", 32'(m0_ack_o), 32'h1);
      check("wr_m1_ack", 32'(m1_ack_o), 32'h0);
      check("wr_m1_dat", m1_dat_o, 32'h0);
      tick();
      s_ack_i = 0;
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
      #1;
      check("wr_m0_ack_end", 32'(m0_ack_o), 32'h0);
      check("wr_gnt_end",    32'(gnt_o), 32'h0);
      check("wr_s_cyc_end",  32'(s_cyc_o), 32'h0);
      tick();

      // ---- m1 read never acked: err in the 9th cycle after grant, m0 pending ----
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h0000_0300;
      tick();
      check("to_gnt", 32'(gnt_o), 32'h2);
      check("to_adr", s_adr_o, 32'h0000_0300);
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0400;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("to_busy_s_cyc", 32'(s_cyc_o), 32'h1);
         check("to_busy_m1_err", 32'(m1_err_o), 32'h0);
      end
      tick();
      check("to_m1_err",  32'(m1_err_o), 32'h1);
      check("to_m0_err",  32'(m0_err_o), 32'h0);
      check("to_s_cyc",   32'(s_cyc_o),  32'h0);
      check("to_s_stb",   32'(s_stb_o),  32'h0);
      check("to_m1_ack",  32'(m1_ack_o), 32'h0);
      check("to_err_gnt", 32'(gnt_o),    32'h2);
      m1_cyc_i = 0; m1_stb_i = 0;
      tick();
      check("to_err_end", 32'(m1_err_o), 32'h0);
      check("to_idle_gnt", 32'(gnt_o), 32'h0);
      tick();
      check("to_next_gnt", 32'(gnt_o), 32'h1);
      check("to_next_adr", s_adr_o, 32'h0000_0400);
      s_ack_i = 1;
      #1;
      check("to_next_m0_ack", 32'(m0_ack_o), 32'h1);
      tick();
      s_ack_i = 0;
      m0_cyc_i = 0; m0_stb_i = 0;
      tick();

      // ---- m0 aborts 3 cycles into BUSY with m1 pending ----
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0500;
      tick();
      check("ab_gnt", 32'(gnt_o), 32'h1);
      m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_0600;
      tick();
      tick();
      check("ab_s_cyc_before", 32'(s_cyc_o), 32'h1);
      m0_cyc_i = 0;
      #1;
      check("ab_s_cyc", 32'(s_cyc_o), 32'h0);
      check("ab_s_stb", 32'(s_stb_o), 32'h0);
      check("ab_m0_ack", 32'(m0_ack_o), 32'h0);
      check("ab_m0_err", 32'(m0_err_o), 32'h0);
      tick();
      m0_stb_i = 0;
      check("ab_idle_gnt", 32'(gnt_o), 32'h0);
      check("ab_idle_m0_err", 32'(m0_err_o), 32'h0);
      tick();
      check("ab_m1_gnt", 32'(gnt_o), 32'h2);
      check("ab_m1_adr", s_adr_o, 32'h0000_0600);
      s_ack_i = 1;
      #1;
      check("ab_m1_ack", 32'(m1_ack_o), 32'h1);
      tick();
      s_ack_i = 0;
      m1_cyc_i = 0; m1_stb_i = 0;
      tick();

      // ---- ack arrives on the watchdog's last cycle: ack wins ----
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0700;
      tick();
      check("co_gnt", 32'(gnt_o), 32'h1);
      for (int k = 1; k <= 7; k++) begin
         tick();
      end
      s_ack_i = 1;
      #1;
      check("co_m0_ack", 32'(m0_ack_o), 32'h1);
      check("co_m0_err", 32'(m0_err_o), 32'h0);
      tick();
      s_ack_i = 0;
      m0_cyc_i = 0; m0_stb_i = 0;
      #1;
      check("co_m0_err_after", 32'(m0_err_o), 32'h0);
      check("co_gnt_after",    32'(gnt_o), 32'h0);
      tick();

      // ---- async reset while m1 is in BUSY, then first tie goes to m0 ----
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
      m1_adr_i = 32'h0000_0800; m1_dat_i = 32'h1234_5678; m1_sel_i = 4'h3;
      tick();
      check("rs_gnt", 32'(gnt_o), 32'h2);
      check("rs_s_stb", 32'(s_stb_o), 32'h1);
      s_ack_i = 1;
      s_dat_i = 32'hCAFE_F00D;
      #1;
      check("rs_m1_ack", 32'(m1_ack_o), 32'h1);
      check("rs_m1_dat", m1_dat_o, 32'hCAFE_F00D);
      #1;
      wb_rst_ni = 1'b0;
      #1;
      check("rs_async_s_cyc", 32'(s_cyc_o), 32'h0);
      check("rs_async_s_stb", 32'(s_stb_o), 32'h0);
      check("rs_async_s_we",  32'(s_we_o),  32'h0);
      check("rs_async_s_adr", s_adr_o, 32'h0);
      check("rs_async_s_dat", s_dat_o, 32'h0);
      check("rs_async_gnt",   32'(gnt_o), 32'h0);
      check("rs_async_m1_ack", 32'(m1_ack_o), 32'h0);
      check("rs_async_m1_dat", m1_dat_o, 32'h0);
      check("rs_async_m1_err", 32'(m1_err_o), 32'h0);
      s_ack_i = 0;
      s_dat_i = '0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
      tick();
      tick();
      wb_rst_ni = 1'b1;
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0900;
      m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_0A00;
      tick();
      check("rs_tie_gnt", 32'(gnt_o), 32'h1);
      check("rs_tie_adr", s_adr_o, 32'h0000_0900);
      s_ack_i = 1;
      #1;
      check("rs_tie_m0_ack", 32'(m0_ack_o), 32'h1);
      check("rs_tie_m1_ack", 32'(m1_ack_o), 32'h0);
      tick();
      s_ack_i = 0;
      m0_cyc_i = 0; m0_stb_i = 0;
      m1_cyc_i = 0; m1_stb_i = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_slave_arbiter.md
Name: wb_slave_arbiter

Overview:
- Two-master Wishbone arbiter in front of the single Wishbone slave port of the user project macro.
- Master 0 is the management SoC Wishbone bus; master 1 is an auxiliary test master driven from logic-analyzer/GPIO logic.
- Grants one master at a time with round-robin fairness, muxes the request onto the slave, and routes ack/data back to the granted master only.
- Per-transaction watchdog returns an error and frees the slave if it never acks.

Parameters:
- TIMEOUT_CYC, 255, max cycles a granted transaction may wait for s_ack_i before it is aborted with err; legal range 1..255.
- CNT_W, 8, width of watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- wb_clk_i  in  1  single clock; all state changes on rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 bus cycle, strobe, write enable.
- m0_adr_i  in  32  master 0 address.
- m0_dat_i  in  32  master 0 write data.
- m0_sel_i  in  4  master 0 byte selects.
- m0_ack_o, m0_err_o  out  1 each  master 0 ack, timeout error.
- m0_dat_o  out  32  master 0 read data.
- m1_* (cyc, stb, we, adr, dat, sel, ack, err, dat_o)  same directions/widths  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave.
- s_adr_o  out  32  to slave.
- s_dat_o  out  32  to slave.
- s_sel_o  out  4  to slave.
- s_ack_i  in  1  slave ack.
- s_dat_i  in  32  slave read data.
- gnt_o  out  2  one-hot current grant (debug/LA visibility).

Behaviour:
- Reset (async assert, sync-released by the system): state=IDLE, owner=none, last_grant=1 (master 0 wins first tie), counter=0, gnt_o=00. All *_ack_o, *_err_o, s_cyc_o, s_stb_o = 0. All data/address outputs = 0.
- Request: mN_req = mN_cyc_i & mN_stb_i.
- IDLE:
  - If exactly one request, grant it.
  - If both request, grant the master not equal to last_grant.
  - Grant is registered: state->BUSY, owner set, counter cleared.
  - No slave outputs are driven in IDLE.
- BUSY:
  - s_cyc_o/s_stb_o = owner cyc&stb; s_we_o, s_adr_o, s_dat_o, s_sel_o = owner's inputs (combinational mux).
  - Owner's dat_o = s_dat_i and ack_o = s_ack_i, combinational in the same cycle.
  - Non-owner ack/err = 0 and dat_o = 0 at all times.
  - On s_ack_i=1: state->IDLE, last_grant=owner. Only one transfer per grant; pipelined/burst mode is not supported.
  - Counter increments each BUSY cycle without ack.
  - When counter==TIMEOUT_CYC-1 and no ack: next cycle state=ERR.
- ERR (1 cycle):
  - Owner err_o=1; s_cyc_o=s_stb_o=0.
  - state->IDLE, last_grant=owner.
- Abort: owner deasserts cyc_i while in BUSY (before ack) -> s_cyc_o drops the same cycle, state->IDLE next edge, last_grant=owner, no ack/err.
- Simultaneous ack and timeout on the same cycle: ack wins, no err.
- Latency: request seen in IDLE at edge N -> s_stb_o high after edge N. Zero-wait slave acks in that cycle, so min turnaround is 2 cycles request-to-ack.
- Back-to-back: IDLE is re-entered for one cycle after every transfer. A waiting other master is granted there, so strict alternation holds under contention.
- gnt_o = one-hot owner in BUSY/ERR, 00 in IDLE.
- Reset asserted mid-transaction: all outputs drop to 0 immediately (async); the transaction is lost, with no ack or err.

Test Plan:
- m0 single write adr=0x3000_0000 dat=0xDEAD_BEEF sel=0xF, slave acks 1 cycle after stb -> s_adr_o/s_dat_o match; m0_ack_o pulses 1 cycle; m1_ack_o stays 0; gnt_o=01 then 00.
- Both masters request at the same edge after reset, 4 reads each, slave returns 0x11 for m0 and 0x22 for m1 -> grants alternate m0,m1,m0,m1...; each master sees only its own data; no ack is misrouted.
- m1 read, slave never acks, TIMEOUT_CYC=8 -> m1_err_o=1 exactly 9 cycles after grant; s_cyc_o low during err; m0 request pending is granted next IDLE.
- m0 drops cyc 3 cycles into BUSY with pending m1 request -> s_cyc_o falls the same cycle; no m0 ack/err; m1 granted on the following IDLE.
- Assert wb_rst_ni=0 while BUSY with s_stb_o=1 -> all outputs 0 without waiting for an edge; after release, first tie goes to m0.
- s_ack_i and the timeout coincide (ack on cycle TIMEOUT_CYC) -> ack delivered, err_o stays 0.
